// File: rtl/stage_pkg.sv
// rtl/stage_pkg.sv - shared defaults and width helper for the conditioning stages
package stage_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEB_CYCLES_DEF  = 4;
  localparam int DIV_DEF         = 8;

  // Counter width that can hold n-1; a single-state counter still gets one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for an asynchronous level
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], d};
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/stage1_condition.sv
// rtl/stage1_condition.sv - synchronise and debounce din into ff1, and generate sample strobe a
module stage1_condition
  import stage_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int DIV         = DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic ff1,
  output logic a,
  output logic chg
);

  localparam int CNT_W = cnt_width(DEB_CYCLES);
  localparam int DIV_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

  generate
    if (SYNC_STAGES < 2 || DEB_CYCLES < 1 || DIV < 2) begin : g_bad_params
      $error("stage1_condition: illegal parameters SYNC_STAGES=%0d DEB_CYCLES=%0d DIV=%0d",
             SYNC_STAGES, DEB_CYCLES, DIV);
    end
  endgenerate

  logic             s;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div;

  sync_chain #(
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (s)
  );

  // Any matching cycle restarts the count; with DEB_CYCLES=1 cnt stays at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ff1 <= 1'b0;
      chg <= 1'b0;
    end else if (s == ff1) begin
      cnt <= '0;
      chg <= 1'b0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
      chg <= 1'b0;
    end else begin
      cnt <= '0;
      ff1 <= s;
      chg <= 1'b1;
    end
  end

  // Dropping en clears the phase, so each enable restarts a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      a   <= 1'b0;
    end else if (!en) begin
      div <= '0;
      a   <= 1'b0;
    end else if (div == DIV_MAX) begin
      div <= '0;
      a   <= 1'b1;
    end else begin
      div <= div + 1'b1;
      a   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage1_condition.sv
// tb/tb_stage1_condition.sv - directed and random checks of stage1_condition against a history model
module tb_stage1_condition;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DIV  = 8;
  localparam int LAT  = SYNC + DEB - 1;

  logic clk = 1'b0;
  logic rst, din, en;
  logic ff1, a, chg;

  int n_vec = 0;
  int n_bad = 0;

  bit din_hist[$];
  bit s_hist[$];
  bit m_ff, m_a, m_chg;
  int en_run;

  always #5 clk = ~clk;

  stage1_condition #(
    .SYNC_STAGES(SYNC),
    .DEB_CYCLES (DEB),
    .DIV        (DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .en (en),
    .ff1(ff1),
    .a  (a),
    .chg(chg)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    din_hist.delete();
    s_hist.delete();
    repeat (SYNC) din_hist.push_back(1'b0);
    m_ff   = 1'b0;
    m_a    = 1'b0;
    m_chg  = 1'b0;
    en_run = 0;
  endtask

  // s seen at an edge is din as sampled SYNC edges earlier; ff1 flips once the
  // last DEB observed s values all disagree with it.
  task automatic model_edge(input bit d, input bit e);
    bit sp, flip;
    sp = din_hist[din_hist.size() - SYNC];
    din_hist.push_back(d);
    if (din_hist.size() > 32) void'(din_hist.pop_front());
    s_hist.push_back(sp);
    if (s_hist.size() > 32) void'(s_hist.pop_front());
    flip = (s_hist.size() >= DEB);
    for (int i = 0; i < DEB; i++)
      if (flip && s_hist[s_hist.size() - 1 - i] == m_ff) flip = 1'b0;
    if (flip) m_ff = ~m_ff;
    m_chg  = flip;
    en_run = e ? en_run + 1 : 0;
    m_a    = e && (en_run % DIV == 0);
  endtask

  task automatic cycle(input bit d, input bit e);
    din = d;
    en  = e;
    @(posedge clk);
    model_edge(d, e);
    @(negedge clk);
    check("ff1", ff1, m_ff);
    check("a", a, m_a);
    check("chg", chg, m_chg);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_ff1", ff1, 1'b0);
    check("rst_a", a, 1'b0);
    check("rst_chg", chg, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit seen_chg, seen_ff;
    bit d, e;
    rst = 1'b1;
    din = 1'b0;
    en  = 1'b0;
    #1;
    check("por_ff1", ff1, 1'b0);
    check("por_a", a, 1'b0);
    check("por_chg", chg, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // step response
    for (int k = 0; k <= LAT + 1; k++) begin
      cycle(1'b1, 1'b0);
      if (k == LAT - 1) check("step_pre", ff1, 1'b0);
      if (k == LAT) begin
        check("step_ff1", ff1, 1'b1);
        check("step_chg", chg, 1'b1);
      end
      if (k == LAT + 1) check("step_chg_off", chg, 1'b0);
    end
    repeat (10) cycle(1'b0, 1'b0);

    // glitch of DEB-1 cycles is rejected
    seen_chg = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle(k < DEB - 1, 1'b0);
      if (chg) seen_chg = 1'b1;
    end
    check("glitch_chg", seen_chg, 1'b0);
    check("glitch_ff1", ff1, 1'b0);

    // DEB-cycle pulse gets through
    seen_ff = 1'b0;
    for (int k = 0; k < 14; k++) begin
      cycle(k < DEB, 1'b0);
      if (ff1) seen_ff = 1'b1;
    end
    check("pulse_ff1", seen_ff, 1'b1);

    // strobe period
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 1'b1);
      check("period_a", a, (k % DIV) == DIV - 1);
    end
    cycle(1'b0, 1'b0);

    // strobe restart after a short disable
    for (int k = 0; k <= 22; k++) begin
      cycle(1'b0, !(k == 11 || k == 12));
      check("restart_a", a, (k == 7 || k == 20));
    end
    cycle(1'b0, 1'b0);

    // ff1 change coincident with a strobe
    for (int k = 0; k <= 7; k++) cycle(k >= 2, 1'b1);
    check("coin_a", a, 1'b1);
    check("coin_chg", chg, 1'b1);
    check("coin_ff1", ff1, 1'b1);

    // reset mid-run, then recovery latency with din held high
    repeat (3) cycle(1'b1, 1'b1);
    async_reset();
    for (int k = 0; k <= LAT; k++) cycle(1'b1, 1'b1);
    check("post_rst_ff1", ff1, 1'b1);

    // random: slow-changing din and en, occasional async reset
    d = 1'b0;
    e = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(5) == 0) d = ~d;
      if ($urandom_range(11) == 0) e = ~e;
      if ($urandom_range(399) == 0) async_reset();
      else cycle(d, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
